// File: rtl/ad_spi_cfg_seq_if.sv
// Bus bundle for ad_spi_cfg_seq: host request, table ROM and spi_wr sides.
// slave is the sequencer's view, master is the driver/ROM/consumer view.
interface ad_spi_cfg_seq_if #(
   parameter int AW = 6
) ();
   logic          start;
   logic          host_wr;
   logic [12:0]   host_addr;
   logic [7:0]    host_data;
   logic          host_ack;
   logic [AW-1:0] rom_addr;
   logic [20:0]   rom_data;
   logic          spi_wr_en;
   logic [12:0]   spi_addr;
   logic [7:0]    spi_data;
   logic          busy;
   logic          done;

   modport slave (
      input  start,
      input  host_wr,
      input  host_addr,
      input  host_data,
      input  rom_data,
      output host_ack,
      output rom_addr,
      output spi_wr_en,
      output spi_addr,
      output spi_data,
      output busy,
      output done
   );

   modport master (
      output start,
      output host_wr,
      output host_addr,
      output host_data,
      output rom_data,
      input  host_ack,
      input  rom_addr,
      input  spi_wr_en,
      input  spi_addr,
      input  spi_data,
      input  busy,
      input  done
   );
endinterface

// File: rtl/ad_spi_cfg_seq.sv
// Config sequencer for the AD SPI write engine: walks an addr/data ROM
// table, one wr_en per entry spaced by XFER_CYCLES, plus single host writes.
module ad_spi_cfg_seq #(
   parameter int AW          = 6,
   parameter int NUM_ENTRIES = 32,
   parameter int XFER_CYCLES = 56
) (
   input logic             clk,
   input logic             rst_n,
   ad_spi_cfg_seq_if.slave bus
);

   localparam int            CW       = $clog2(XFER_CYCLES);
   localparam logic [20:0]   END_MARK = 21'h1FFFFF;
   localparam logic [AW-1:0] LAST     = AW'(NUM_ENTRIES - 1);
   localparam logic [CW-1:0] CNT_LD   = CW'(XFER_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LATCH,
      ISSUE,
      WAIT,
      DONE
   } state_t;

   state_t        state;
   logic [AW-1:0] idx;
   logic [CW-1:0] cnt;
   logic          host_flg;

   // Sequencer FSM; every output is a register updated alongside the state.
   // rom_addr is advanced one state early (on start and on the idx step) so
   // the sync ROM output is already valid when LATCH samples it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         idx           <= '0;
         cnt           <= '0;
         host_flg      <= 1'b0;
         bus.rom_addr  <= '0;
         bus.spi_wr_en <= 1'b0;
         bus.spi_addr  <= '0;
         bus.spi_data  <= '0;
         bus.host_ack  <= 1'b0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
      end else begin
         bus.spi_wr_en <= 1'b0;
         bus.host_ack  <= 1'b0;
         unique case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  state        <= FETCH;
                  idx          <= '0;
                  bus.rom_addr <= '0;
                  host_flg     <= 1'b0;
                  bus.done     <= 1'b0;
                  bus.busy     <= 1'b1;
               end else if (bus.host_wr) begin
                  state         <= ISSUE;
                  host_flg      <= 1'b1;
                  bus.host_ack  <= 1'b1;
                  bus.spi_addr  <= bus.host_addr;
                  bus.spi_data  <= bus.host_data;
                  bus.spi_wr_en <= 1'b1;
                  bus.busy      <= 1'b1;
               end
            end
            FETCH: begin
               bus.rom_addr <= idx;
               state        <= LATCH;
            end
            LATCH: begin
               if (bus.rom_data == END_MARK) begin
                  state    <= DONE;
                  bus.done <= 1'b1;
                  bus.busy <= 1'b0;
               end else begin
                  bus.spi_addr  <= bus.rom_data[20:8];
                  bus.spi_data  <= bus.rom_data[7:0];
                  bus.spi_wr_en <= 1'b1;
                  state         <= ISSUE;
               end
            end
            ISSUE: begin
               cnt   <= CNT_LD;
               state <= WAIT;
            end
            WAIT: begin
               if (cnt != '0) begin
                  cnt <= cnt - CW'(1);
               end else if (host_flg) begin
                  host_flg <= 1'b0;
                  bus.busy <= 1'b0;
                  state    <= bus.done ? DONE : IDLE;
               end else if (idx == LAST) begin
                  state    <= DONE;
                  bus.done <= 1'b1;
                  bus.busy <= 1'b0;
               end else begin
                  idx          <= idx + AW'(1);
                  bus.rom_addr <= idx + AW'(1);
                  state        <= FETCH;
               end
            end
            default: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
